// File: rtl/serial_addsub_unit.sv
// Digit-serial adder/subtractor: D bits per clock, LSB digit first, registered carry.
// State table:  IDLE | waiting for start   RUN | processing digits   DONE | one-cycle done pulse
module serial_addsub_unit #(
  parameter int N = 8,
  parameter int D = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sub,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  localparam int NDIG = N / D;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  if (N < 2 || D < 1 || D > N || (N % D) != 0) begin : g_param_check
    $error("serial_addsub_unit: invalid N/D combination");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [N-1:0]  sa;
  logic [N-1:0]  sb;
  logic          carry;
  logic [CW-1:0] cnt;
  logic [N-1:0]  res;

  logic [D:0]    dsum;
  logic          msb_cin;
  logic [N-1:0]  res_next;
  logic          last_digit;

  assign dsum       = {1'b0, sa[D-1:0]} + {1'b0, sb[D-1:0]} + (D+1)'(carry);
  // carry into the digit's top bit, recovered from its sum bit and operand bits
  assign msb_cin    = dsum[D-1] ^ sa[D-1] ^ sb[D-1];
  assign last_digit = (cnt == CW'(NDIG - 1));

  if (D == N) begin : g_full_digit
    assign res_next = dsum[N-1:0];
  end else begin : g_part_digit
    assign res_next = {dsum[D-1:0], res[N-1:D]};
  end

  assign sum = res;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      sa    <= '0;
      sb    <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      res   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            sa    <= a;
            sb    <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
            res   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          res   <= res_next;
          sa    <= sa >> D;
          sb    <= sb >> D;
          carry <= dsum[D];
          cnt   <= cnt + CW'(1);
          if (last_digit) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            cout  <= dsum[D];
            ovf   <= msb_cin ^ dsum[D];
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub_unit.sv
// Scoreboard bench for serial_addsub_unit: one N=8/D=1 and one N=8/D=4 instance.
module tb_serial_addsub_unit;

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start1 = 1'b0, start4 = 1'b0;
  logic       sub = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       busy1, done1, cout1, ovf1;
  logic       busy4, done4, cout4, ovf4;
  logic [7:0] sum1, sum4;

  int   cyc = 0;
  int   nchk = 0;
  int   nerr = 0;
  exp_t q1[$];
  exp_t q4[$];
  exp_t e1, e4;

  serial_addsub_unit #(.N(8), .D(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .sub(sub), .a(a), .b(b),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1));

  serial_addsub_unit #(.N(8), .D(4)) u4 (
    .clk(clk), .rst(rst), .start(start4), .sub(sub), .a(a), .b(b),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [7:0] x, input logic [7:0] y, input logic s);
    exp_t       m;
    logic [7:0] yy;
    logic [8:0] f;
    yy     = s ? ~y : y;
    f      = {1'b0, x} + {1'b0, yy} + 9'(s);
    m.sum  = f[7:0];
    m.cout = f[8];
    m.ovf  = (x[7] == yy[7]) && (f[7] != x[7]);
    m.cyc  = 0;
    return m;
  endfunction

  always @(negedge clk) if (rst) begin
    if (busy1 && done1) chk("busy_done_excl_d1", 1, 0);
    if (done1) begin
      if (q1.size() == 0) chk("unexpected_done_d1", 1, 0);
      else begin
        e1 = q1.pop_front();
        chk("sum_d1", sum1, e1.sum);
        chk("cout_d1", cout1, e1.cout);
        chk("ovf_d1", ovf1, e1.ovf);
        chk("done_cycle_d1", cyc, e1.cyc);
      end
    end
  end

  always @(negedge clk) if (rst) begin
    if (busy4 && done4) chk("busy_done_excl_d4", 1, 0);
    if (done4) begin
      if (q4.size() == 0) chk("unexpected_done_d4", 1, 0);
      else begin
        e4 = q4.pop_front();
        chk("sum_d4", sum4, e4.sum);
        chk("cout_d4", cout4, e4.cout);
        chk("ovf_d4", ovf4, e4.ovf);
        chk("done_cycle_d4", cyc, e4.cyc);
      end
    end
  end

  task automatic wait_done(input int w);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      seen = (w == 1) ? done1 : done4;
    end
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  task automatic run_op(input int w, input logic [7:0] ta, input logic [7:0] tb_v, input logic ts);
    exp_t e;
    int   ndig;
    ndig = (w == 1) ? 8 : 2;
    e = model(ta, tb_v, ts);
    @(posedge clk); #1;
    a = ta; b = tb_v; sub = ts;
    e.cyc = cyc + 1 + ndig;
    if (w == 1) begin q1.push_back(e); start1 = 1'b1; end
    else        begin q4.push_back(e); start4 = 1'b1; end
    @(posedge clk); #1;
    start1 = 1'b0; start4 = 1'b0;
    chk("busy_after_accept", (w == 1) ? busy1 : busy4, 1);
    wait_done(w);
    @(negedge clk);
    chk("sum_hold", (w == 1) ? sum1 : sum4, e.sum);
    chk("idle_after_done", (w == 1) ? busy1 : busy4, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    #2;
    chk("rst_busy", busy1 | busy4, 0);
    chk("rst_done", done1 | done4, 0);
    chk("rst_sum", {sum1, sum4}, 0);
    chk("rst_flags", {cout1, ovf1, cout4, ovf4}, 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;

    run_op(1, 8'h3C, 8'h25, 1'b0);
    run_op(1, 8'h10, 8'h20, 1'b1);
    run_op(1, 8'h20, 8'h10, 1'b1);
    run_op(1, 8'h7F, 8'h01, 1'b0);
    run_op(1, 8'h80, 8'h01, 1'b1);
    run_op(4, 8'hFF, 8'h01, 1'b0);
    run_op(4, 8'h7F, 8'h01, 1'b0);
    run_op(4, 8'h80, 8'h01, 1'b1);
    run_op(4, 8'h5A, 8'hC3, 1'b1);

    // start pulses during RUN must be ignored
    e = model(8'h12, 8'h34, 1'b0);
    @(posedge clk); #1;
    a = 8'h12; b = 8'h34; sub = 1'b0; start1 = 1'b1;
    e.cyc = cyc + 9; q1.push_back(e);
    @(posedge clk); #1; start1 = 1'b0; a = 8'hFF; b = 8'hFF; sub = 1'b1;
    @(posedge clk); #1; start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0;
    @(posedge clk);
    @(posedge clk); #1; start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0;
    wait_done(1);
    repeat (12) @(negedge clk);
    chk("ignored_start_sum", sum1, 8'h46);

    // start held high: back-to-back every 9 cycles
    @(posedge clk); #1;
    a = 8'h01; b = 8'h02; sub = 1'b0; start1 = 1'b1;
    e = model(8'h01, 8'h02, 1'b0); e.cyc = cyc + 9;  q1.push_back(e);
    @(posedge clk); #1;
    a = 8'h90; b = 8'h90; sub = 1'b0;
    e = model(8'h90, 8'h90, 1'b0); e.cyc = cyc + 17; q1.push_back(e);
    repeat (9) @(posedge clk); #1;
    a = 8'h05; b = 8'h09; sub = 1'b1;
    e = model(8'h05, 8'h09, 1'b1); e.cyc = cyc + 17; q1.push_back(e);
    repeat (9) @(posedge clk); #1;
    start1 = 1'b0;
    wait_done(1);
    repeat (3) @(negedge clk);
    chk("b2b_drained", q1.size(), 0);

    // asynchronous reset mid-RUN
    @(posedge clk); #1;
    a = 8'hAA; b = 8'h55; sub = 1'b0; start1 = 1'b1;
    e = model(8'hAA, 8'h55, 1'b0); e.cyc = cyc + 9; q1.push_back(e);
    @(posedge clk); #1; start1 = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("arst_busy", busy1, 0);
    chk("arst_done", done1, 0);
    chk("arst_sum", sum1, 0);
    chk("arst_flags", {cout1, ovf1}, 0);
    q1.delete();
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    run_op(1, 8'h01, 8'h01, 1'b0);
    repeat (10) @(negedge clk);

    chk("q1_empty", q1.size(), 0);
    chk("q4_empty", q4.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/serial_addsub_unit.md
# serial_addsub_unit

Parametrised digit-serial adder/subtractor. It loads two N-bit operands on a start handshake and processes D bits per clock, LSB digit first, through a registered carry. It returns the N-bit result with carry-out and signed-overflow flags, plus a one-cycle done pulse. It is the next generation of the team's bit-serial adder, generalised in width, digit size and mode, and adds explicit control handshaking for use inside larger datapaths.

## Interface
- N, default 8: operand and result width in bits; N ≥ 2.
- D, default 1: digit width, i.e. bits processed per cycle; 1 ≤ D ≤ N. N must be divisible by D (elaboration error otherwise).
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- start  input  1  request a new operation; sampled on the rising edge.
- sub  input  1  mode: 0 = a+b, 1 = a−b. Captured together with the operands.
- a  input  N  operand A; captured when start is accepted.
- b  input  N  operand B; captured when start is accepted.
- busy  output  1  operation in progress; start is ignored while high.
- done  output  1  one-cycle pulse; result valid.
- sum  output  N  result; held from done until the next accepted start.
- cout  output  1  carry out of the MSB. For subtraction, 1 means no borrow.
- ovf  output  1  two's-complement signed overflow of the result.

## Operation
- States:
  - IDLE: waiting for start.
  - RUN: processing digits.
  - DONE: one cycle, done=1.
- IDLE or DONE with start=1 at an edge: accept the request and go to RUN.
  - Capture a into shift register SA.
  - Capture b into SB, or ~b when sub=1.
  - Carry register ← sub (0 for add, 1 for sub).
  - Digit counter ← 0. Result register cleared to 0.
  - cout and ovf cleared.
- RUN, each edge:
  - {c, s} = SA[D−1:0] + SB[D−1:0] + carry, a (D+1)-bit sum.
  - s is shifted into the result from the top: result ← {s, result[N−1:D]}.
  - SA and SB shift right by D; carry ← c; counter increments.
- On the edge processing the last digit (counter = N/D−1):
  - Go to DONE.
  - cout ← c.
  - ovf ← carry into MSB XOR carry out of MSB. For D>1 this is computed inside the final digit, not from the digit carry alone.
- DONE lasts exactly one cycle. It returns to IDLE unless start=1, which gives a back-to-back accept.
- start while busy=1 is ignored; the operation in flight is unaffected.
- Operand inputs a, b and sub are don't-care except on the accepting edge.
- Results are modulo 2^N. The full-width carry is exposed only through cout.

## Timing
- Reset asserted (rst=0), asynchronously:
  - state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0.
  - Carry, counter and shift registers = 0.
- Reset mid-operation aborts immediately. No done is produced.
- After reset is released, the first rising edge with start=1 is accepted.
- Latency, start accepted at edge k:
  - busy=1 after edge k.
  - Digits are processed at edges k+1 … k+N/D.
  - busy falls and done rises after edge k+N/D.
  - done falls after edge k+N/D+1.
- Throughput: one operation per N/D+1 cycles when start is held high. The restart is accepted on the DONE edge.
- sum, cout and ovf are final and stable from the done pulse until the next accepted start. They are then cleared on the accepting edge.
- busy and done are never high simultaneously.
- Intermediate sum contents during RUN are not specified for consumers.

## Test plan
- N=8, D=1, add 0x3C+0x25:
  - Required: sum=0x61, cout=0, ovf=0.
  - busy high 8 cycles; done pulses exactly at edge k+8 for one cycle.
- N=8, D=1, sub 0x10−0x20:
  - Required: sum=0xF0, cout=0 (borrow), ovf=0.
  - Then sub 0x20−0x10: sum=0x10, cout=1.
- N=8, D=1, overflow cases:
  - 0x7F+0x01: sum=0x80, ovf=1, cout=0.
  - 0x80−0x01: sum=0x7F, ovf=1, cout=1.
- N=8, D=4, add 0xFF+0x01:
  - Required: sum=0x00, cout=1, ovf=0.
  - done at edge k+2; latency matches N/D.
- Handshake:
  - Pulse start again at cycles 2 and 5 of a running operation: ignored, result unchanged.
  - start held high continuously: back-to-back operations every 9 cycles (N=8, D=1), each with the correct result.
- Reset:
  - Drop rst mid-RUN, asynchronously between edges.
  - Required: all outputs 0 immediately; no done pulse.
  - The next start after release computes 0x01+0x01=0x02 correctly.
